// File: rtl/test_seq_runner.sv
// rtl/test_seq_runner.sv - sequences reset/request/wait over an array of req/busy/return test channels
module test_seq_runner #(
    parameter int N_TESTS        = 4,
    parameter int RESET_CYCLES   = 6,
    parameter int START_DELAY    = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RESET_EACH     = 1,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [N_TESTS-1:0] test_req,
    input  logic [N_TESTS-1:0] test_busy,
    input  logic [N_TESTS-1:0] test_return,
    output logic               dut_reset,
    output logic [4:0]         cur_idx,
    output logic               busy,
    output logic               done,
    output logic               pass_all,
    output logic [N_TESTS-1:0] pass_mask,
    output logic [N_TESTS-1:0] timeout_mask
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_REQ,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] TMO         = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [4:0]       LAST_IDX    = 5'(N_TESTS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [4:0]         idx_q, idx_d;
    logic [N_TESTS-1:0] pass_q, pass_d;
    logic [N_TESTS-1:0] tmo_q, tmo_d;
    logic [N_TESTS-1:0] req_q, req_d;
    logic [N_TESTS-1:0] sel, sel_next;
    logic               dut_reset_q, dut_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_all_q, pass_all_d;
    logic               active, sel_busy, sel_ret, hit_tmo;

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_TESTS; i++) begin
            sel[i] = (idx_q == 5'(i));
        end
        active   = (state_q != S_IDLE) && (state_q != S_DONE);
        sel_busy = |(test_busy & sel);
        sel_ret  = |(test_return & sel);
        cnt_inc  = cnt_q + 1'b1;
        // Fires on the cycle whose increment would reach the limit, so req is high exactly TIMEOUT_CYCLES cycles
        hit_tmo  = (cnt_inc >= TMO);

        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;

        if (abort && active) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        state_d = S_RST;
                        cnt_d   = '0;
                        idx_d   = '0;
                        pass_d  = '0;
                        tmo_d   = '0;
                    end
                end
                S_RST: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_d   = '0;
                        state_d = (START_DELAY > 0) ? S_SETTLE : S_REQ;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_REQ, S_WAIT: begin
                    cnt_d = hit_tmo ? TMO : cnt_inc;
                    if (hit_tmo) begin
                        tmo_d   = tmo_q | sel;
                        pass_d  = pass_q & ~sel;
                        state_d = S_NEXT;
                    end else if (state_q == S_REQ && sel_busy) begin
                        state_d = S_WAIT;
                    end else if (state_q == S_WAIT && !sel_busy) begin
                        pass_d  = sel_ret ? (pass_q | sel) : (pass_q & ~sel);
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = (RESET_EACH != 0) ? S_RST :
                                  (START_DELAY > 0) ? S_SETTLE : S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered copies of what the next state implies
        sel_next = '0;
        for (int i = 0; i < N_TESTS; i++) begin
            sel_next[i] = (idx_d == 5'(i));
        end
        req_d       = (state_d == S_REQ) ? sel_next : '0;
        dut_reset_d = (state_d == S_RST);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        pass_all_d  = done_d && (&pass_d) && !(|tmo_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            tmo_q       <= '0;
            req_q       <= '0;
            dut_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_all_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            tmo_q       <= tmo_d;
            req_q       <= req_d;
            dut_reset_q <= dut_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_all_q  <= pass_all_d;
        end
    end

    assign test_req     = req_q;
    assign dut_reset    = dut_reset_q;
    assign cur_idx      = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass_all     = pass_all_q;
    assign pass_mask    = pass_q;
    assign timeout_mask = tmo_q;

endmodule
